// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the register-group decoder's host request port
// between NUM_REQ requesters, with its own completion timeout.
module reg_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_rd_wr_L,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]        rsp_vld,
  output logic [DATA_W-1:0]         rsp_rd_data,
  output logic                      rsp_err,
  output logic                      fifo_empty,
  input  logic                      fifo_rd_en,
  output logic                      bus_rd_wr_L,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wr_data,
  input  logic [DATA_W-1:0]         bus_rd_data,
  input  logic                      bus_rd_vld,
  input  logic                      bus_ack,
  output logic [15:0]               timeout_count
);

  localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, owner_q;
  logic [PTR_W-1:0]    grant_idx, next_ptr;
  logic                grant_vld;
  logic [TMR_W-1:0]    timer_q;
  logic                bus_rd_wr_L_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wr_data_q;
  logic [DATA_W-1:0]   rsp_rd_data_q;
  logic                rsp_err_q;
  logic [15:0]         timeout_count_q;
  logic                wait_done, wait_tmo;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    next_ptr = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_vld   = '0;
    wait_done = 1'b0;
    wait_tmo  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready = NUM_REQ'(1) << grant_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (fifo_rd_en) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        // Completion beats a timeout landing in the same cycle.
        wait_done = bus_rd_wr_L_q ? bus_rd_vld : bus_ack;
        wait_tmo  = !wait_done && (timer_q == TMR_W'(TIMEOUT));
        if (wait_done || wait_tmo) state_d = RESP;
      end
      RESP: begin
        rsp_vld = NUM_REQ'(1) << owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      timer_q         <= '0;
      bus_rd_wr_L_q   <= 1'b1;
      bus_addr_q      <= '0;
      bus_wr_data_q   <= '0;
      rsp_rd_data_q   <= '0;
      rsp_err_q       <= 1'b0;
      timeout_count_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            rr_ptr_q      <= next_ptr;
            owner_q       <= grant_idx;
            bus_rd_wr_L_q <= req_rd_wr_L[grant_idx];
            bus_addr_q    <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            bus_wr_data_q <= req_wr_data[int'(grant_idx)*DATA_W +: DATA_W];
          end
        end
        ISSUE: begin
          if (fifo_rd_en) timer_q <= '0;
        end
        WAIT_RSP: begin
          timer_q <= timer_q + TMR_W'(1);
          if (wait_done) begin
            if (bus_rd_wr_L_q) rsp_rd_data_q <= bus_rd_data;
            rsp_err_q <= 1'b0;
          end else if (wait_tmo) begin
            rsp_rd_data_q   <= DATA_W'(32'hDEADBEEF);
            rsp_err_q       <= 1'b1;
            timeout_count_q <= sat_inc16(timeout_count_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_empty    = (state_q != ISSUE);
  assign bus_rd_wr_L   = bus_rd_wr_L_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wr_data   = bus_wr_data_q;
  assign rsp_rd_data   = rsp_rd_data_q;
  assign rsp_err       = rsp_err_q;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: grants, reads, writes, timeouts,
// stray strobes, mid-transaction reset and timeout-counter saturation.
module tb_reg_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 27;
  localparam int DATA_W  = 32;
  localparam int TO      = 1023;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_rd_wr_L;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wr_data;
  logic [NUM_REQ-1:0]        rsp_vld;
  logic [DATA_W-1:0]         rsp_rd_data;
  logic                      rsp_err;
  logic                      fifo_empty;
  logic                      fifo_rd_en;
  logic                      bus_rd_wr_L;
  logic [ADDR_W-1:0]         bus_addr;
  logic [DATA_W-1:0]         bus_wr_data;
  logic [DATA_W-1:0]         bus_rd_data;
  logic                      bus_rd_vld;
  logic                      bus_ack;
  logic [15:0]               timeout_count;

  int n_checks = 0;
  int n_fail   = 0;

  reg_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd_wr_L(req_rd_wr_L),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .rsp_vld(rsp_vld), .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .bus_rd_wr_L(bus_rd_wr_L), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rd_vld(bus_rd_vld), .bus_ack(bus_ack),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input bit rd, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd);
    req_rd_wr_L[r]                = rd;
    req_addr[r*ADDR_W +: ADDR_W]  = a;
    req_wr_data[r*DATA_W +: DATA_W] = wd;
  endtask

  // Called at a negedge in IDLE with the requester's valid already raised.
  task automatic run_txn(input int own, input bit rd, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input int lat,
                         input logic [DATA_W-1:0] rdata, input bit respond,
                         input bit drop, input bit exp_err,
                         input logic [DATA_W-1:0] exp_rd);
    int n;
    #1;
    check("grant", req_ready, 64'(1) << own);
    @(negedge clk);
    if (drop) req_valid[own] = 1'b0;
    check("ready_one_cycle", req_ready, 0);
    check("issue_empty", fifo_empty, 0);
    check("issue_rw", bus_rd_wr_L, rd);
    check("issue_addr", bus_addr, addr);
    if (!rd) check("issue_wdata", bus_wr_data, wd);
    @(negedge clk);
    check("issue_hold", fifo_empty, 0);
    fifo_rd_en = 1'b1;
    @(negedge clk);
    fifo_rd_en = 1'b0;
    check("wait_empty", fifo_empty, 1);
    if (respond) begin
      repeat (lat) @(negedge clk);
      check("wait_rw_stable", bus_rd_wr_L, rd);
      if (!rd) check("wait_wdata_stable", bus_wr_data, wd);
      if (rd) begin
        bus_rd_vld  = 1'b1;
        bus_rd_data = rdata;
      end else begin
        bus_ack = 1'b1;
      end
      @(negedge clk);
    end else begin
      n = 0;
      while (rsp_vld == 0 && n < TO + 20) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycles", n, TO + 1);
    end
    check("rsp_vld", rsp_vld, 64'(1) << own);
    check("rsp_err", rsp_err, exp_err);
    if (rd || exp_err) check("rsp_data", rsp_rd_data, exp_rd);
    // Strobe lingers through RESP; it must not produce a second response.
    @(negedge clk);
    bus_rd_vld = 1'b0;
    bus_ack    = 1'b0;
    check("rsp_single", rsp_vld, 0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_rd_wr_L = '1; req_addr = '0; req_wr_data = '0;
    fifo_rd_en = 1'b0; bus_rd_data = '0; bus_rd_vld = 1'b0; bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_rsp_data", rsp_rd_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_bus_rw", bus_rd_wr_L, 1);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wd", bus_wr_data, 0);
    check("rst_tmo_cnt", timeout_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Contention: both held valid, grants alternate starting at 0.
    set_req(0, 1'b1, 27'h0000100, 32'h0);
    set_req(1, 1'b1, 27'h0000200, 32'h0);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++)
      run_txn(i % 2, 1'b1, (i % 2 == 0) ? 27'h0000100 : 27'h0000200, 32'h0, 1,
              32'hA0000000 + 32'(i), 1'b1, 1'b0, 1'b0, 32'hA0000000 + 32'(i));
    req_valid = '0;
    @(negedge clk);

    // Single read on requester 0.
    set_req(0, 1'b1, 27'h0400040, 32'h0);
    req_valid[0] = 1'b1;
    run_txn(0, 1'b1, 27'h0400040, 32'h0, 2, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h12345678);

    // Write with ack on requester 1.
    set_req(1, 1'b0, 27'h0000404, 32'hCAFEF00D);
    req_valid[1] = 1'b1;
    run_txn(1, 1'b0, 27'h0000404, 32'hCAFEF00D, 3, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Write that never acks: forced completion.
    set_req(0, 1'b0, 27'h0000808, 32'h11112222);
    req_valid[0] = 1'b1;
    run_txn(0, 1'b0, 27'h0000808, 32'h11112222, 0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
    check("tmo_cnt_one", timeout_count, 1);

    // Ack arriving exactly on the timeout cycle still counts as completion.
    set_req(1, 1'b0, 27'h0000C0C, 32'h33334444);
    req_valid[1] = 1'b1;
    run_txn(1, 1'b0, 27'h0000C0C, 32'h33334444, TO, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("tmo_cnt_still_one", timeout_count, 1);

    // Stray strobes in IDLE.
    bus_ack = 1'b1; bus_rd_vld = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0; bus_rd_vld = 1'b0;
    check("stray_idle_rsp", rsp_vld, 0);
    check("stray_idle_empty", fifo_empty, 1);
    @(negedge clk);
    check("stray_idle_rsp2", rsp_vld, 0);

    // Stray strobes in ISSUE, then reset while waiting.
    set_req(0, 1'b1, 27'h0000010, 32'h0);
    req_valid[0] = 1'b1;
    #1;
    check("mid_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    bus_ack = 1'b1; bus_rd_vld = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0; bus_rd_vld = 1'b0;
    check("stray_issue_empty", fifo_empty, 0);
    check("stray_issue_rsp", rsp_vld, 0);
    fifo_rd_en = 1'b1;
    @(negedge clk);
    fifo_rd_en = 1'b0;
    check("mid_wait_empty", fifo_empty, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_empty", fifo_empty, 1);
    check("mid_rst_rsp", rsp_vld, 0);
    check("mid_rst_addr", bus_addr, 0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_quiet", rsp_vld, 0);
    end
    // rr pointer back at 0: requester 0 wins, then requester 1.
    set_req(0, 1'b1, 27'h0000020, 32'h0);
    set_req(1, 1'b1, 27'h0000030, 32'h0);
    req_valid = 2'b11;
    run_txn(0, 1'b1, 27'h0000020, 32'h0, 0, 32'h55AA55AA, 1'b1, 1'b1, 1'b0, 32'h55AA55AA);
    run_txn(1, 1'b1, 27'h0000030, 32'h0, 0, 32'h0F0F0F0F, 1'b1, 1'b1, 1'b0, 32'h0F0F0F0F);

    // Saturation of the timeout counter from a preloaded value.
    force dut.timeout_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.timeout_count_q;
    @(negedge clk);
    check("preload", timeout_count, 16'hFFFE);
    for (int k = 0; k < 2; k++) begin
      set_req(k, 1'b0, 27'h0000040, 32'h0);
      req_valid[k] = 1'b1;
      run_txn(k, 1'b0, 27'h0000040, 32'h0, 0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
      check("sat_cnt", timeout_count, 16'hFFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the single host register-access port of the register-group decoder between NUM_REQ independent requesters, e.g. the PCIe host path and the Ethernet control-packet path.
- Each requester uses a valid/ready request channel and receives a one-cycle response pulse.
- The arbiter runs one transaction at a time in round-robin order.
- Downstream it drives the decoder's FIFO-style request interface (fifo_empty/fifo_rd_en).
- It enforces its own completion timeout, so writes that never ack cannot hang a requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 27, byte address width (matches CPCI_NF2_ADDR_WIDTH).
- DATA_W, 32, data width.
- TIMEOUT, 1023, WAIT_RSP cycles before forced completion. Must be > 515 so it exceeds the decoder's internal 512-cycle timeout plus pipeline.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_rd_wr_L  in  NUM_REQ  1=read, 0=write
- req_addr  in  NUM_REQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W]
- req_wr_data  in  NUM_REQ*DATA_W  flattened write data
- rsp_vld  out  NUM_REQ  one-cycle completion pulse to the owning requester
- rsp_rd_data  out  DATA_W  read data; valid only while rsp_vld is high
- rsp_err  out  1  timeout flag; qualified by rsp_vld
- fifo_empty  out  1  0 = request pending to the decoder
- fifo_rd_en  in  1  decoder pop strobe
- bus_rd_wr_L  out  1  latched request type
- bus_addr  out  ADDR_W  latched address
- bus_wr_data  out  DATA_W  latched write data
- bus_rd_data  in  DATA_W  decoder read data
- bus_rd_vld  in  1  decoder read completion
- bus_ack  in  1  decoder ack (out_ack of the decoder)
- timeout_count  out  16  saturating count of arbiter timeouts

Behaviour:
- Reset values:
  - State IDLE; rr_ptr=0; req_ready=0; rsp_vld=0; rsp_rd_data=0; rsp_err=0.
  - fifo_empty=1; bus_rd_wr_L=1; bus_addr=0; bus_wr_data=0; timeout_count=0.
  - Reset mid-transaction aborts silently: no rsp_vld is issued, and the decoder shares the reset.
- States: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE:
  - Winner = first requester with req_valid set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle.
  - On that edge, latch rd_wr_L/addr/wr_data into the bus_* registers, store the owner index, set rr_ptr=(winner+1) mod NUM_REQ, and go to ISSUE.
  - No valid requests: stay in IDLE with fifo_empty=1.
- ISSUE:
  - fifo_empty=0.
  - On fifo_rd_en=1, go to WAIT_RSP and clear the timer.
  - The bus_* registers hold stable from the IDLE latch until the next IDLE grant; the decoder samples them the cycle after fifo_rd_en.
- WAIT_RSP:
  - fifo_empty=1; the timer increments each cycle.
  - Read: completes on bus_rd_vld=1. Capture bus_rd_data; rsp_err=0.
  - Write: completes on bus_ack=1; rsp_err=0.
  - Simultaneous completion and timer==TIMEOUT: completion wins.
  - Timer==TIMEOUT with no completion: rsp_rd_data=32'hDEADBEEF, rsp_err=1, timeout_count increments (saturating at 16'hFFFF).
  - Any completion path goes to RESP.
- RESP:
  - rsp_vld[owner]=1 for exactly one cycle, then go to IDLE.
  - Minimum request-to-request gap for one requester is 4 cycles plus decoder latency.
- Stray inputs: bus_rd_vld/bus_ack outside WAIT_RSP are ignored. This covers the lingering decoder ack one cycle after completion.
- req_valid may drop without acceptance (no stickiness); a request is committed only by valid & ready.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.

Test Plan:
- Single read: req0 addr 0x0400040, decoder returns 0x12345678 -> req_ready[0] for 1 cycle, fifo_empty low until fifo_rd_en, then rsp_vld[0] with data 0x12345678 and rsp_err=0.
- Contention: req0 and req1 valid in the same IDLE cycle after reset -> req0 granted first, req1 next. Repeat with both held valid for 6 transactions -> grant order 0,1,0,1,0,1.
- Write with ack: req1 write 0xCAFEF00D -> bus_wr_data=0xCAFEF00D and bus_rd_wr_L=0 stable through WAIT_RSP; bus_ack -> rsp_vld[1], rsp_err=0.
- Write with no ack for 1023 cycles -> rsp_vld with rsp_err=1 and rsp_rd_data=0xDEADBEEF; timeout_count=1. bus_ack on the timeout cycle instead -> rsp_err=0.
- Stray bus_ack/bus_rd_vld pulsed in IDLE and ISSUE -> no rsp_vld and no state change; reset asserted during WAIT_RSP -> fifo_empty=1, state IDLE, no rsp_vld.
- Saturation: force 65537 timeouts, or preload via a bench force -> timeout_count stays at 0xFFFF.
